// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Bytes arrive on a valid/ready write port and are presented show-ahead on
// data_out. The head byte is handed to the transmitter (start) on every cycle
// the transmitter reports txe while the FIFO holds data.
// Optional feature macro: UART_TX_FIFO_LEVEL_EN exposes the occupancy count
// on the `level` port. Without it the count stays internal.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                wr_valid,
    input  logic [7:0]          wr_data,
    output logic                wr_ready,
    input  logic                txe,
    output logic                start,
    output logic [7:0]          data_out,
    output logic                overflow
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,  count_d;
    logic                  overflow_q, overflow_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Status flags and handshakes; only registered state and txe feed outputs.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_COUNT);
        push     = wr_valid && !full;
        pop      = txe && !empty;
        wr_ready = !full;
        start    = pop;
        data_out = empty ? 8'h00 : mem_q[rd_ptr_q];
        overflow = overflow_q;
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    // Occupancy export.
    always_comb begin
        level = count_q;
    end
`endif

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A write while full is dropped even if a pop frees a slot this cycle.
        if (wr_valid && full) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH_LOG2 = 4).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       txe = 1'b0;
    logic       wr_ready;
    logic       start;
    logic [7:0] data_out;
    logic       overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .txe      (txe),
        .start    (start),
        .data_out (data_out),
        .overflow (overflow)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    // Stimulus only: enqueue one byte with txe low.
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        txe      = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        wr_valid = 1'b0;
        txe      = 1'b0;
        nrst     = 1'b0;
        #1;
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`ifdef UART_TX_FIFO_LEVEL_EN
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
`endif
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        txe  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL idle_start cycle %0d: got %b expected 0", i, start); end
        end
        txe = 1'b0;
    endtask

    task automatic test_order();
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = hello[i];
            txe      = 1'b0;
            #1;
            n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL order_wr_ready %0d: got %b expected 1", i, wr_ready); end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        n_checks++; if (data_out !== 8'h48) begin n_fail++; $display("FAIL order_showahead: got %h expected 48", data_out); end
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL order_start_txe0: got %b expected 0", start); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            txe = 1'b1;
            #1;
            n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL order_start %0d: got %b expected 1", i, start); end
            n_checks++; if (data_out !== hello[i]) begin n_fail++; $display("FAIL order_data %0d: got %h expected %h", i, data_out, hello[i]); end
            @(negedge clk);
            txe = 1'b0;
            #1;
            n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL order_pulse_end %0d: got %b expected 0", i, start); end
        end
        txe = 1'b1;
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL order_empty_start: got %b expected 0", start); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL order_empty_data: got %h expected 00", data_out); end
        txe = 1'b0;
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = 8'h10 + 8'(i);
            txe      = 1'b0;
            #1;
            n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill_ready %0d: got %b expected 1", i, wr_ready); end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready: got %b expected 0", wr_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_overflow_yet: got %b expected 0", overflow); end
`ifdef UART_TX_FIFO_LEVEL_EN
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d expected 16", level); end
`endif
        // 17th write alongside a pop: byte must be dropped.
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        txe      = 1'b1;
        #1;
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL full_pop_start: got %b expected 1", start); end
        n_checks++; if (data_out !== 8'h10) begin n_fail++; $display("FAIL full_pop_data: got %h expected 10", data_out); end
        @(negedge clk);
        wr_valid = 1'b0;
        txe      = 1'b0;
        #1;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL overflow_wr_ready: got %b expected 1", wr_ready); end
`ifdef UART_TX_FIFO_LEVEL_EN
        n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL overflow_level: got %0d expected 15", level); end
`endif
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            txe = 1'b1;
            #1;
            n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL full_drain_start %0d: got %b expected 1", i, start); end
            n_checks++; if (data_out !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL full_drain_data %0d: got %h expected %h", i, data_out, 8'h10 + 8'(i)); end
        end
        @(negedge clk);
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL full_drained_start: got %b expected 0", start); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
        txe = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        int pushed = 0;
        int popped = 0;
        int cycles = 0;
        int mcnt   = 0;
        logic do_pop;
        while (popped < 40 && cycles < 1000) begin
            @(negedge clk);
            wr_valid = (pushed < 40) && (mcnt < 16);
            wr_data  = 8'(pushed * 7 + 3);
            txe      = (pushed >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            do_pop = txe && (mcnt != 0);
            n_checks++; if (wr_ready !== (mcnt < 16)) begin n_fail++; $display("FAIL wrap_wr_ready cyc %0d: got %b expected %b", cycles, wr_ready, (mcnt < 16)); end
            n_checks++; if (start !== do_pop) begin n_fail++; $display("FAIL wrap_start cyc %0d: got %b expected %b", cycles, start, do_pop); end
            if (do_pop) begin
                n_checks++; if (data_out !== q[0]) begin n_fail++; $display("FAIL wrap_data pop %0d: got %h expected %h", popped, data_out, q[0]); end
                void'(q.pop_front());
                popped++;
            end
`ifdef UART_TX_FIFO_LEVEL_EN
            n_checks++; if (level !== 5'(mcnt)) begin n_fail++; $display("FAIL wrap_level cyc %0d: got %0d expected %0d", cycles, level, mcnt); end
`endif
            if (wr_valid) begin
                q.push_back(wr_data);
                pushed++;
            end
            mcnt = q.size();
            cycles++;
        end
        n_checks++; if (popped !== 40) begin n_fail++; $display("FAIL wrap_timeout: got %0d pops expected 40", popped); end
        @(negedge clk);
        wr_valid = 1'b0;
        txe      = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        push_byte(8'hA0);
        push_byte(8'hA1);
        push_byte(8'hA2);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 8'hA3;
        txe      = 1'b1;
        #1;
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL simul_start: got %b expected 1", start); end
        n_checks++; if (data_out !== 8'hA0) begin n_fail++; $display("FAIL simul_head: got %h expected a0", data_out); end
        @(negedge clk);
        wr_valid = 1'b0;
        txe      = 1'b0;
        #1;
        n_checks++; if (data_out !== 8'hA1) begin n_fail++; $display("FAIL simul_new_head: got %h expected a1", data_out); end
`ifdef UART_TX_FIFO_LEVEL_EN
        n_checks++; if (level !== 5'd3) begin n_fail++; $display("FAIL simul_level: got %0d expected 3", level); end
`endif
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            txe = 1'b1;
            #1;
            n_checks++; if (data_out !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL simul_drain %0d: got %h expected %h", i, data_out, 8'hA0 + 8'(i)); end
        end
        @(negedge clk);
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got %b expected 0", start); end
        txe = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) push_byte(8'hB0 + 8'(i));
        @(negedge clk);
        txe = 1'b1;
        #1;
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL arst_pre_start: got %b expected 1", start); end
        n_checks++; if (data_out !== 8'hB0) begin n_fail++; $display("FAIL arst_pre_data: got %h expected b0", data_out); end
        #1;
        nrst = 1'b0;
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL arst_start_drop: got %b expected 0", start); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %h expected 00", data_out); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL arst_wr_ready: got %b expected 1", wr_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_overflow_clear: got %b expected 0", overflow); end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        txe  = 1'b0;
        #1;
`ifdef UART_TX_FIFO_LEVEL_EN
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL arst_level: got %0d expected 0", level); end
`endif
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL arst_post_data: got %h expected 00", data_out); end
        push_byte(8'hC5);
        txe = 1'b1;
        #1;
        n_checks++; if (start !== 1'b1) begin n_fail++; $display("FAIL arst_new_start: got %b expected 1", start); end
        n_checks++; if (data_out !== 8'hC5) begin n_fail++; $display("FAIL arst_new_data: got %h expected c5", data_out); end
        @(negedge clk);
        txe = 1'b0;
        #1;
        n_checks++; if (start !== 1'b0) begin n_fail++; $display("FAIL arst_final_start: got %b expected 0", start); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL arst_final_data: got %h expected 00", data_out); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_full_overflow();
        test_wrap();
        test_simul_push_pop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
